// File: rtl/mem_pkg.sv
// Shared encodings for the byte-serial memory: access sizes, controller states, size-to-byte-count helper.
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] SIZE_RSVD = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    XFER = 2'd2
  } state_e;

  // Reserved size maps to zero bytes; callers reject it before using the count.
  function automatic logic [2:0] size_to_bytes(input logic [1:0] sz);
    case (sz)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      SIZE_WORD: return 3'd4;
      default:   return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Single-port byte RAM, one write or read per cycle; combinational read, synchronous write.
// Synchronous reset clears every byte, so the array is held in flops.
module mem_byte_array #(
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we_i,
  input  logic [ADDRESS_WIDTH-1:0] addr_i,
  input  logic [7:0]               wdata_i,
  output logic [7:0]               rdata_o
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/byte_serial_memory.sv
// Byte/halfword/word memory controller: big-endian, one byte per cycle after WAIT_CYCLES idle cycles.
// Defining MEM_ALIGN_CHECK_EN rejects misaligned halfword/word requests as error completions.
module byte_serial_memory
  import mem_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int WAIT_CYCLES   = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     rwn,
  input  logic [1:0]               size,
  input  logic [ADDRESS_WIDTH-1:0] address,
  input  logic [31:0]              data_in,
  output logic [31:0]              data_out,
  output logic                     ready,
  output logic                     done,
  output logic                     error
);

  localparam bit         HAS_WAIT  = (WAIT_CYCLES > 0);
  localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e                   state_q, state_d;
  logic                     rwn_q, rwn_d;
  logic [2:0]               rem_q, rem_d;
  logic [3:0]               wcnt_q, wcnt_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]              shreg_q, shreg_d;
  logic [31:0]              data_out_q, data_out_d;
  logic                     done_q, done_d;
  logic                     error_q, error_d;

  logic                     req_err;
  logic [31:0]              wr_align;
  logic                     mem_we;
  logic [7:0]               mem_rdata;

  always_comb begin
    req_err = (size == SIZE_RSVD);
`ifdef MEM_ALIGN_CHECK_EN
    if ((size == SIZE_HALF && address[0]) ||
        (size == SIZE_WORD && address[1:0] != 2'b00)) begin
      req_err = 1'b1;
    end
`endif
  end

  // Writes are left-aligned so the next byte to commit is always shreg_q[31:24].
  always_comb begin
    case (size)
      SIZE_BYTE: wr_align = {data_in[7:0], 24'h0};
      SIZE_HALF: wr_align = {data_in[15:0], 16'h0};
      default:   wr_align = data_in;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    rwn_d      = rwn_q;
    rem_d      = rem_q;
    wcnt_d     = wcnt_q;
    addr_d     = addr_q;
    shreg_d    = shreg_q;
    data_out_d = data_out_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    mem_we     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (req_err) begin
            done_d  = 1'b1;
            error_d = 1'b1;
          end else begin
            rwn_d   = rwn;
            addr_d  = address;
            rem_d   = size_to_bytes(size);
            shreg_d = rwn ? 32'h0 : wr_align;
            wcnt_d  = WAIT_LOAD;
            state_d = HAS_WAIT ? WAIT : XFER;
          end
        end
      end

      WAIT: begin
        if (wcnt_q == 4'd0) begin
          state_d = XFER;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end

      XFER: begin
        mem_we  = ~rwn_q;
        // Shared shifter: writes drain from the top, reads fill from the bottom.
        shreg_d = {shreg_q[23:0], mem_rdata};
        addr_d  = addr_q + ADDRESS_WIDTH'(1);
        rem_d   = rem_q - 3'd1;
        if (rem_q == 3'd1) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (rwn_q) begin
            data_out_d = {shreg_q[23:0], mem_rdata};
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rwn_q      <= 1'b0;
      rem_q      <= 3'd0;
      wcnt_q     <= 4'd0;
      addr_q     <= '0;
      shreg_q    <= 32'h0;
      data_out_q <= 32'h0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rwn_q      <= rwn_d;
      rem_q      <= rem_d;
      wcnt_q     <= wcnt_d;
      addr_q     <= addr_d;
      shreg_q    <= shreg_d;
      data_out_q <= data_out_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  mem_byte_array #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .we_i    (mem_we),
    .addr_i  (addr_q),
    .wdata_i (shreg_q[31:24]),
    .rdata_o (mem_rdata)
  );

  assign ready    = (state_q == IDLE);
  assign done     = done_q;
  assign error    = error_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_byte_serial_memory.sv
// Scoreboard bench for byte_serial_memory: one instance with no wait states, one with WAIT_CYCLES=3.
module tb_byte_serial_memory;
  import mem_pkg::*;

  typedef struct packed {
    logic        rwn;
    logic [1:0]  size;
    logic [7:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        err;
    logic [7:0]  lat;
  } req_t;

  typedef struct packed {
    logic [31:0] dout;
    logic        err;
    logic [7:0]  lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        a_start = 1'b0, a_rwn = 1'b0;
  logic [1:0]  a_size = 2'd0;
  logic [7:0]  a_addr = 8'h0;
  logic [31:0] a_din = 32'h0;
  logic [31:0] a_dout;
  logic        a_ready, a_done, a_err;

  logic        b_start = 1'b0, b_rwn = 1'b0;
  logic [1:0]  b_size = 2'd0;
  logic [7:0]  b_addr = 8'h0;
  logic [31:0] b_din = 32'h0;
  logic [31:0] b_dout;
  logic        b_ready, b_done, b_err;

  logic        cur_sel = 1'b0;
  logic        m_ready, m_done, m_err;
  logic [31:0] m_dout;
  assign m_ready = cur_sel ? b_ready : a_ready;
  assign m_done  = cur_sel ? b_done  : a_done;
  assign m_err   = cur_sel ? b_err   : a_err;
  assign m_dout  = cur_sel ? b_dout  : a_dout;

  byte_serial_memory #(.ADDRESS_WIDTH(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .start(a_start), .rwn(a_rwn), .size(a_size),
    .address(a_addr), .data_in(a_din), .data_out(a_dout), .ready(a_ready),
    .done(a_done), .error(a_err)
  );

  byte_serial_memory #(.ADDRESS_WIDTH(8), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .start(b_start), .rwn(b_rwn), .size(b_size),
    .address(b_addr), .data_in(b_din), .data_out(b_dout), .ready(b_ready),
    .done(b_done), .error(b_err)
  );

  function automatic req_t mk(input logic rw, input logic [1:0] sz, input logic [7:0] ad,
                              input logic [31:0] dn, input logic [31:0] exp_dout,
                              input logic exp_err, input int exp_lat);
    req_t r;
    r.rwn = rw; r.size = sz; r.addr = ad; r.din = dn;
    r.dout = exp_dout; r.err = exp_err; r.lat = 8'(exp_lat);
    return r;
  endfunction

  task automatic drive(input bit sel, input logic st, input logic rw, input logic [1:0] sz,
                       input logic [7:0] ad, input logic [31:0] dn);
    if (sel) begin
      b_start = st; b_rwn = rw; b_size = sz; b_addr = ad; b_din = dn;
    end else begin
      a_start = st; a_rwn = rw; a_size = sz; a_addr = ad; a_din = dn;
    end
  endtask

  task automatic drive_junk(input bit sel);
    drive(sel, 1'b0, 1'($urandom), 2'($urandom), 8'($urandom), $urandom);
  endtask

  // Issue one request; expected result is queued at issue and popped at completion.
  task automatic run(input bit sel, input req_t r, output exp_t e, output exp_t o, output logic rdy);
    exp_t t;
    int   guard = 0;
    cur_sel = sel;
    t.dout = r.dout; t.err = r.err; t.lat = r.lat;
    sb_q.push_back(t);
    #0;
    while (m_ready !== 1'b1 && guard < 64) begin
      @(posedge clk); #1; guard++;
    end
    drive(sel, 1'b1, r.rwn, r.size, r.addr, r.din);
    @(posedge clk); #1;
    drive_junk(sel);
    o.lat = 8'hFF; o.err = 1'bx; o.dout = 'x; rdy = 1'bx;
    for (int k = 0; k < 64; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (m_done === 1'b1) begin
        o.lat = 8'(k); o.err = m_err; o.dout = m_dout; rdy = m_ready;
        break;
      end
    end
    e = sb_q.pop_front();
  endtask

  task automatic test_reset();
    exp_t e, o; logic rdy;
    n_tests++;
    if ({a_ready, a_done, a_err, a_dout} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset0: ready=%b done=%b err=%b dout=%h, want 1 0 0 00000000", a_ready, a_done, a_err, a_dout);
    end
    n_tests++;
    if ({b_ready, b_done, b_err, b_dout} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset3: ready=%b done=%b err=%b dout=%h, want 1 0 0 00000000", b_ready, b_done, b_err, b_dout);
    end
    run(1'b0, mk(1'b1, SIZE_WORD, 8'h10, 32'h0, 32'h0, 1'b0, 4), e, o, rdy);
    n_tests++;
    if (o !== e || rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_word_rd: dout=%h err=%b lat=%0d rdy=%b, want dout=%h err=%b lat=%0d rdy=1",
               o.dout, o.err, o.lat, rdy, e.dout, e.err, e.lat);
    end
  endtask

  task automatic test_write_read();
    req_t tbl[6]; exp_t e, o; logic rdy;
    tbl[0] = mk(1'b0, SIZE_WORD, 8'h20, 32'hDEADBEEF, 32'h0,      1'b0, 4);
    tbl[1] = mk(1'b1, SIZE_BYTE, 8'h20, 32'h0,       32'hDE,     1'b0, 1);
    tbl[2] = mk(1'b1, SIZE_BYTE, 8'h21, 32'h0,       32'hAD,     1'b0, 1);
    tbl[3] = mk(1'b1, SIZE_BYTE, 8'h22, 32'h0,       32'hBE,     1'b0, 1);
    tbl[4] = mk(1'b1, SIZE_BYTE, 8'h23, 32'h0,       32'hEF,     1'b0, 1);
    tbl[5] = mk(1'b1, SIZE_HALF, 8'h22, 32'h0,       32'hBEEF,   1'b0, 2);
    foreach (tbl[i]) begin
      run(1'b0, tbl[i], e, o, rdy);
      n_tests++;
      if (o !== e || rdy !== 1'b1) begin
        n_fail++;
        $display("FAIL write_read[%0d]: dout=%h err=%b lat=%0d rdy=%b, want dout=%h err=%b lat=%0d rdy=1",
                 i, o.dout, o.err, o.lat, rdy, e.dout, e.err, e.lat);
      end
    end
  endtask

  task automatic test_wait_states();
    req_t tbl[3]; exp_t e, o; logic rdy;
    tbl[0] = mk(1'b0, SIZE_BYTE, 8'h01, 32'h5A, 32'h0,         1'b0, 4);
    tbl[1] = mk(1'b1, SIZE_BYTE, 8'h01, 32'h0,  32'h5A,        1'b0, 4);
    tbl[2] = mk(1'b1, SIZE_WORD, 8'h00, 32'h0,  32'h005A0000,  1'b0, 7);
    foreach (tbl[i]) begin
      run(1'b1, tbl[i], e, o, rdy);
      n_tests++;
      if (o !== e || rdy !== 1'b1) begin
        n_fail++;
        $display("FAIL wait_states[%0d]: dout=%h err=%b lat=%0d rdy=%b, want dout=%h err=%b lat=%0d rdy=1",
                 i, o.dout, o.err, o.lat, rdy, e.dout, e.err, e.lat);
      end
    end
  endtask

`ifdef MEM_ALIGN_CHECK_EN
  task automatic test_align();
    req_t tbl[8]; exp_t e, o; logic rdy;
    tbl[0] = mk(1'b0, SIZE_WORD, 8'h21, 32'h12345678, 32'hBEEF, 1'b1, 0);
    tbl[1] = mk(1'b0, SIZE_HALF, 8'h23, 32'h0000FFFF, 32'hBEEF, 1'b1, 0);
    tbl[2] = mk(1'b1, SIZE_BYTE, 8'h24, 32'h0,        32'h00,   1'b0, 1);
    tbl[3] = mk(1'b1, SIZE_BYTE, 8'h21, 32'h0,        32'hAD,   1'b0, 1);
    tbl[4] = mk(1'b1, SIZE_BYTE, 8'h22, 32'h0,        32'hBE,   1'b0, 1);
    tbl[5] = mk(1'b1, SIZE_BYTE, 8'h23, 32'h0,        32'hEF,   1'b0, 1);
    tbl[6] = mk(1'b1, SIZE_RSVD, 8'h20, 32'h0,        32'hEF,   1'b1, 0);
    tbl[7] = mk(1'b1, SIZE_HALF, 8'h20, 32'h0,        32'hDEAD, 1'b0, 2);
    foreach (tbl[i]) begin
      run(1'b0, tbl[i], e, o, rdy);
      n_tests++;
      if (o !== e || rdy !== 1'b1) begin
        n_fail++;
        $display("FAIL align[%0d]: dout=%h err=%b lat=%0d rdy=%b, want dout=%h err=%b lat=%0d rdy=1",
                 i, o.dout, o.err, o.lat, rdy, e.dout, e.err, e.lat);
      end
    end
  endtask
`else
  task automatic test_wrap();
    req_t tbl[8]; exp_t e, o; logic rdy;
    tbl[0] = mk(1'b0, SIZE_WORD, 8'hFE, 32'h11223344, 32'hBEEF,     1'b0, 4);
    tbl[1] = mk(1'b1, SIZE_BYTE, 8'hFE, 32'h0,        32'h11,       1'b0, 1);
    tbl[2] = mk(1'b1, SIZE_BYTE, 8'hFF, 32'h0,        32'h22,       1'b0, 1);
    tbl[3] = mk(1'b1, SIZE_BYTE, 8'h00, 32'h0,        32'h33,       1'b0, 1);
    tbl[4] = mk(1'b1, SIZE_BYTE, 8'h01, 32'h0,        32'h44,       1'b0, 1);
    tbl[5] = mk(1'b1, SIZE_WORD, 8'hFF, 32'h0,        32'h22334400, 1'b0, 4);
    tbl[6] = mk(1'b1, SIZE_HALF, 8'h21, 32'h0,        32'hADBE,     1'b0, 2);
    tbl[7] = mk(1'b1, SIZE_RSVD, 8'h20, 32'h0,        32'hADBE,     1'b1, 0);
    foreach (tbl[i]) begin
      run(1'b0, tbl[i], e, o, rdy);
      n_tests++;
      if (o !== e || rdy !== 1'b1) begin
        n_fail++;
        $display("FAIL wrap[%0d]: dout=%h err=%b lat=%0d rdy=%b, want dout=%h err=%b lat=%0d rdy=1",
                 i, o.dout, o.err, o.lat, rdy, e.dout, e.err, e.lat);
      end
    end
  endtask
`endif

  task automatic test_back_to_back();
    req_t tbl[5]; exp_t e, o; logic rdy;
    tbl[0] = mk(1'b0, SIZE_WORD, 8'h40, 32'hA5A55A5A, 32'h0,        1'b0, 4);
    tbl[1] = mk(1'b1, SIZE_WORD, 8'h40, 32'h0,        32'hA5A55A5A, 1'b0, 4);
    tbl[2] = mk(1'b0, SIZE_HALF, 8'h44, 32'hFFFF1234, 32'hA5A55A5A, 1'b0, 2);
    tbl[3] = mk(1'b1, SIZE_HALF, 8'h44, 32'h0,        32'h1234,     1'b0, 2);
    tbl[4] = mk(1'b1, SIZE_BYTE, 8'h45, 32'h0,        32'h34,       1'b0, 1);
    // The first write's held data_out depends on the previous test, so fix it up from its table.
`ifdef MEM_ALIGN_CHECK_EN
    tbl[0].dout = 32'hDEAD;
`else
    tbl[0].dout = 32'hADBE;
`endif
    foreach (tbl[i]) begin
      run(1'b0, tbl[i], e, o, rdy);
      n_tests++;
      if (o !== e || rdy !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b[%0d]: dout=%h err=%b lat=%0d rdy=%b, want dout=%h err=%b lat=%0d rdy=1",
                 i, o.dout, o.err, o.lat, rdy, e.dout, e.err, e.lat);
      end
    end
  endtask

  task automatic test_busy_ignore();
    req_t tbl[2]; exp_t t, e, o; logic rdy; int extra = 0;
    cur_sel = 1'b0;
    t.dout = 32'h34; t.err = 1'b0; t.lat = 8'd4;
    sb_q.push_back(t);
    drive(1'b0, 1'b1, 1'b0, SIZE_WORD, 8'h50, 32'hCAFEBABE);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, SIZE_BYTE, 8'h54, 32'h77);
    o.lat = 8'hFF; o.err = 1'bx; o.dout = 'x;
    for (int k = 1; k < 64; k++) begin
      @(posedge clk); #1;
      if (k == 3) drive_junk(1'b0);
      if (a_done === 1'b1) begin
        o.lat = 8'(k); o.err = a_err; o.dout = a_dout;
        break;
      end
    end
    e = sb_q.pop_front();
    n_tests++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL busy_write: dout=%h err=%b lat=%0d, want dout=%h err=%b lat=%0d",
               o.dout, o.err, o.lat, e.dout, e.err, e.lat);
    end
    repeat (3) begin
      @(posedge clk); #1;
      if (a_done !== 1'b0) extra++;
    end
    n_tests++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL busy_extra_done: %0d spurious done cycles, want 0", extra);
    end
    tbl[0] = mk(1'b1, SIZE_WORD, 8'h50, 32'h0, 32'hCAFEBABE, 1'b0, 4);
    tbl[1] = mk(1'b1, SIZE_BYTE, 8'h54, 32'h0, 32'h00,       1'b0, 1);
    foreach (tbl[i]) begin
      run(1'b0, tbl[i], e, o, rdy);
      n_tests++;
      if (o !== e || rdy !== 1'b1) begin
        n_fail++;
        $display("FAIL busy_rd[%0d]: dout=%h err=%b lat=%0d rdy=%b, want dout=%h err=%b lat=%0d rdy=1",
                 i, o.dout, o.err, o.lat, rdy, e.dout, e.err, e.lat);
      end
    end
  endtask

  task automatic test_reset_abort();
    req_t tbl[4]; exp_t e, o; logic rdy; int seen = 0;
    drive(1'b0, 1'b1, 1'b0, SIZE_WORD, 8'h30, 32'hFFFFFFFF);
    @(posedge clk); #1;
    drive_junk(1'b0);
    @(posedge clk); #1;
    if (a_done !== 1'b0) seen++;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_tests++;
    if ({a_ready, a_done, a_err, a_dout} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL abort_state: ready=%b done=%b err=%b dout=%h, want 1 0 0 00000000", a_ready, a_done, a_err, a_dout);
    end
    repeat (4) begin
      @(posedge clk); #1;
      if (a_done !== 1'b0) seen++;
    end
    n_tests++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL abort_no_done: %0d done cycles, want 0", seen);
    end
    tbl[0] = mk(1'b1, SIZE_BYTE, 8'h30, 32'h0, 32'h0, 1'b0, 1);
    tbl[1] = mk(1'b1, SIZE_WORD, 8'h30, 32'h0, 32'h0, 1'b0, 4);
    tbl[2] = mk(1'b1, SIZE_WORD, 8'h20, 32'h0, 32'h0, 1'b0, 4);
    tbl[3] = mk(1'b1, SIZE_WORD, 8'h40, 32'h0, 32'h0, 1'b0, 4);
    foreach (tbl[i]) begin
      run(1'b0, tbl[i], e, o, rdy);
      n_tests++;
      if (o !== e || rdy !== 1'b1) begin
        n_fail++;
        $display("FAIL abort_rd[%0d]: dout=%h err=%b lat=%0d rdy=%b, want dout=%h err=%b lat=%0d rdy=1",
                 i, o.dout, o.err, o.lat, rdy, e.dout, e.err, e.lat);
      end
    end
    run(1'b1, mk(1'b1, SIZE_BYTE, 8'h01, 32'h0, 32'h0, 1'b0, 4), e, o, rdy);
    n_tests++;
    if (o !== e || rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_rd_w3: dout=%h err=%b lat=%0d rdy=%b, want dout=%h err=%b lat=%0d rdy=1",
               o.dout, o.err, o.lat, rdy, e.dout, e.err, e.lat);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_write_read();
    test_wait_states();
`ifdef MEM_ALIGN_CHECK_EN
    test_align();
`else
    test_wrap();
`endif
    test_back_to_back();
    test_busy_ignore();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
